// File: rtl/cbf_lut_pkg.sv
// Shared types and width helpers for the complex LUT bank.
package cbf_lut_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUILD = 2'd1,
    READY = 2'd2
  } state_t;

  // Address/index width that never collapses to zero bits.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Table entry width: one extra bit so a negated most-negative coefficient fits.
  function automatic int unsigned lut_w(input int unsigned data_w, input int unsigned sel_w);
    return data_w + $clog2(sel_w) + 1;
  endfunction

  // Output width after summing n_lut table entries.
  function automatic int unsigned out_w(input int unsigned lw, input int unsigned n_lut);
    return lw + $clog2(n_lut);
  endfunction

endpackage

// File: rtl/cplx_lut_table.sv
// One complex LUT: SEL_W coefficients and a 2**SEL_W entry table with a
// build port (one entry per cycle) and a registered read port.
module cplx_lut_table
  import cbf_lut_pkg::*;
#(
  parameter int unsigned SEL_W  = 4,
  parameter int unsigned DATA_W = 18
) (
  input  logic                                clk,
  input  logic                                coef_we,
  input  logic [clog2_min1(SEL_W)-1:0]        coef_idx,
  input  logic [DATA_W-1:0]                   coef_re,
  input  logic [DATA_W-1:0]                   coef_im,
  input  logic                                build_we,
  input  logic [SEL_W-1:0]                    build_k,
  input  logic                                rd_en,
  input  logic [SEL_W-1:0]                    rd_sel,
  output logic [lut_w(DATA_W, SEL_W)-1:0]     rd_re,
  output logic [lut_w(DATA_W, SEL_W)-1:0]     rd_im
);

  localparam int unsigned LUT_W = lut_w(DATA_W, SEL_W);
  localparam int unsigned DEPTH = 2 ** SEL_W;

  logic signed [DATA_W-1:0] c_re [SEL_W];
  logic signed [DATA_W-1:0] c_im [SEL_W];
  logic signed [LUT_W-1:0]  t_re [DEPTH];
  logic signed [LUT_W-1:0]  t_im [DEPTH];
  logic signed [LUT_W-1:0]  ent_re;
  logic signed [LUT_W-1:0]  ent_im;

  // Coefficient storage, not reset.
  always_ff @(posedge clk) begin
    if (coef_we) begin
      c_re[coef_idx] <= coef_re;
      c_im[coef_idx] <= coef_im;
    end
  end

  // Entry k = sum over j of (+coef[j] if k[j] else -coef[j]), sign-extended first.
  always_comb begin
    ent_re = '0;
    ent_im = '0;
    for (int j = 0; j < SEL_W; j++) begin
      if (build_k[j]) begin
        ent_re = ent_re + LUT_W'(c_re[j]);
        ent_im = ent_im + LUT_W'(c_im[j]);
      end else begin
        ent_re = ent_re - LUT_W'(c_re[j]);
        ent_im = ent_im - LUT_W'(c_im[j]);
      end
    end
  end

  // Table write during BUILD, one entry per cycle.
  always_ff @(posedge clk) begin
    if (build_we) begin
      t_re[build_k] <= ent_re;
      t_im[build_k] <= ent_im;
    end
  end

  // Registered read port (lookup stage 1).
  always_ff @(posedge clk) begin
    if (rd_en) begin
      rd_re <= t_re[rd_sel];
      rd_im <= t_im[rd_sel];
    end
  end

endmodule

// File: rtl/cplx_lut_bank.sv
// Runtime-programmable bank of N_LUT complex LUTs: sequential table build,
// parallel lookup and summation with a fixed 2-cycle latency.
module cplx_lut_bank
  import cbf_lut_pkg::*;
#(
  parameter int unsigned SEL_W  = 4,
  parameter int unsigned N_LUT  = 4,
  parameter int unsigned DATA_W = 18
) (
  input  logic                                          clk,
  input  logic                                          rstn,
  input  logic                                          coef_wr_en,
  input  logic [clog2_min1(N_LUT*SEL_W)-1:0]            coef_addr,
  input  logic [DATA_W-1:0]                             coef_re,
  input  logic [DATA_W-1:0]                             coef_im,
  input  logic                                          build_start,
  output logic                                          busy,
  input  logic                                          in_valid,
  output logic                                          in_ready,
  input  logic [N_LUT*SEL_W-1:0]                        in_sel,
  output logic                                          out_valid,
  output logic [out_w(lut_w(DATA_W, SEL_W), N_LUT)-1:0] out_re,
  output logic [out_w(lut_w(DATA_W, SEL_W), N_LUT)-1:0] out_im
);

  localparam int unsigned N_COEF = N_LUT * SEL_W;
  localparam int unsigned IDX_W  = clog2_min1(SEL_W);
  localparam int unsigned LUT_W  = lut_w(DATA_W, SEL_W);
  localparam int unsigned OUT_W  = out_w(LUT_W, N_LUT);

  state_t           state;
  state_t           state_nx;
  logic [SEL_W-1:0] k;
  logic [SEL_W-1:0] k_nx;
  logic             wr_ok;
  logic             accept;
  logic             s1_valid;

  logic signed [LUT_W-1:0] rd_re [N_LUT];
  logic signed [LUT_W-1:0] rd_im [N_LUT];
  logic signed [OUT_W-1:0] sum_re;
  logic signed [OUT_W-1:0] sum_im;

  // Writes to addresses beyond the coefficient space are dropped entirely.
  assign wr_ok    = coef_wr_en && (32'(coef_addr) < N_COEF);
  assign in_ready = (state == READY) && !coef_wr_en && !build_start;
  assign accept   = in_valid && in_ready;

  // FSM state, build counter and busy flag.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= IDLE;
      k     <= '0;
      busy  <= 1'b0;
    end else begin
      state <= state_nx;
      k     <= k_nx;
      busy  <= (state_nx == BUILD);
    end
  end

  // Next state: a coefficient write always wins over build_start.
  always_comb begin
    state_nx = state;
    k_nx     = k;
    case (state)
      IDLE: begin
        if (!wr_ok && build_start) begin
          state_nx = BUILD;
          k_nx     = '0;
        end
      end
      BUILD: begin
        if (wr_ok) begin
          k_nx = '0;
        end else if (k == '1) begin
          state_nx = READY;
          k_nx     = '0;
        end else begin
          k_nx = k + SEL_W'(1);
        end
      end
      READY: begin
        if (wr_ok) begin
          state_nx = IDLE;
        end else if (build_start) begin
          state_nx = BUILD;
          k_nx     = '0;
        end
      end
      default: begin
        state_nx = IDLE;
        k_nx     = '0;
      end
    endcase
  end

  // Table instances with coefficient address decode.
  for (genvar t = 0; t < N_LUT; t++) begin : g_lut
    localparam int unsigned LUT_IDX = t;
    logic             hit;
    logic [IDX_W-1:0] idx;

    assign hit = wr_ok && ((32'(coef_addr) / SEL_W) == LUT_IDX);
    assign idx = IDX_W'(32'(coef_addr) % SEL_W);

    cplx_lut_table #(
      .SEL_W  (SEL_W),
      .DATA_W (DATA_W)
    ) u_table (
      .clk      (clk),
      .coef_we  (hit),
      .coef_idx (idx),
      .coef_re  (coef_re),
      .coef_im  (coef_im),
      .build_we (state == BUILD),
      .build_k  (k),
      .rd_en    (accept),
      .rd_sel   (in_sel[t*SEL_W +: SEL_W]),
      .rd_re    (rd_re[t]),
      .rd_im    (rd_im[t])
    );
  end

  // Adder tree over the stage-1 table reads, exact after sign extension.
  always_comb begin
    sum_re = '0;
    sum_im = '0;
    for (int t = 0; t < N_LUT; t++) begin
      sum_re = sum_re + OUT_W'(rd_re[t]);
      sum_im = sum_im + OUT_W'(rd_im[t]);
    end
  end

  // Lookup pipeline valids and output register (stage 2).
  always_ff @(posedge clk) begin
    if (!rstn) begin
      s1_valid  <= 1'b0;
      out_valid <= 1'b0;
      out_re    <= '0;
      out_im    <= '0;
    end else begin
      s1_valid  <= accept;
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_re <= sum_re;
        out_im <= sum_im;
      end
    end
  end

endmodule
